// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing controller for the iterative multiply/divide
// datapath. Walks LOAD -> RUN (ITER cycles) -> FIX -> DONE per operation.
// A start pulse in any busy state restarts the sequence with the new mode.
// Every output is a decode of registered state; no input reaches an output
// combinationally.
module multdiv_ctrl #(
   parameter int ITER = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ctrl_MULT,
   input  logic       ctrl_DIV,
   input  logic       divisor_zero,
   input  logic       mult_ovf,
   output logic       dp_load,
   output logic       dp_step,
   output logic       dp_fix,
   output logic       dp_mode,
   output logic [5:0] iter_idx,
   output logic       busy,
   output logic       result_rdy,
   output logic       exception
);

   if (ITER < 1 || ITER > 63) begin : g_iter_chk
      $error("multdiv_ctrl: ITER must be in 1..63");
   end

   localparam logic [5:0] LAST = 6'(ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t     state;
   logic [5:0] cnt;
   logic       mode;   // 0 = multiply, 1 = divide
   logic       flag;   // pending exception for the current operation
   logic       start;

   assign start = ctrl_MULT | ctrl_DIV;

   // Sequencer: reset first, then any start pulse (re)launches from LOAD
   // with multiply winning a tie, otherwise step through the sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 6'd0;
         mode  <= 1'b0;
         flag  <= 1'b0;
      end else if (start) begin
         state <= S_LOAD;
         cnt   <= 6'd0;
         mode  <= ~ctrl_MULT;
         flag  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: cnt <= 6'd0;
            S_LOAD: begin
               cnt <= 6'd0;
               // Divide by zero skips the iterations entirely.
               if (mode && divisor_zero) begin
                  flag  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               // Counter holds at LAST on the final iterate cycle.
               if (cnt == LAST) state <= S_FIX;
               else             cnt   <= cnt + 6'd1;
            end
            S_FIX: begin
               flag  <= ~mode & mult_ovf;
               state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign dp_load    = (state == S_LOAD);
   assign dp_step    = (state == S_RUN);
   assign dp_fix     = (state == S_FIX);
   assign result_rdy = (state == S_DONE);
   assign exception  = (state == S_DONE) & flag;
   assign busy       = (state != S_IDLE);
   assign dp_mode    = busy & mode;
   assign iter_idx   = (state == S_RUN) ? cnt : 6'd0;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: drives two controllers (ITER=32 and ITER=1) and checks
// every output against a timeline model: each operation is described by
// the cycle its LOAD occupies, and expected outputs come from the offset
// of the current cycle within that operation.
module tb_multdiv_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mult0 = 1'b0, div0 = 1'b0, mult1 = 1'b0, div1 = 1'b0;
   logic       dz = 1'b0, ovf = 1'b0;

   logic       dp_load0, dp_step0, dp_fix0, dp_mode0, busy0, result_rdy0, exception0;
   logic [5:0] iter_idx0;
   logic       dp_load1, dp_step1, dp_fix1, dp_mode1, busy1, result_rdy1, exception1;
   logic [5:0] iter_idx1;

   logic [12:0] obs0, obs1;
   assign obs0 = {dp_load0, dp_step0, dp_fix0, dp_mode0, iter_idx0, busy0, result_rdy0, exception0};
   assign obs1 = {dp_load1, dp_step1, dp_fix1, dp_mode1, iter_idx1, busy1, result_rdy1, exception1};

   int ntests = 0;
   int nfail  = 0;

   multdiv_ctrl #(.ITER(32)) u0 (
      .clk(clk), .rst(rst), .ctrl_MULT(mult0), .ctrl_DIV(div0),
      .divisor_zero(dz), .mult_ovf(ovf),
      .dp_load(dp_load0), .dp_step(dp_step0), .dp_fix(dp_fix0), .dp_mode(dp_mode0),
      .iter_idx(iter_idx0), .busy(busy0), .result_rdy(result_rdy0), .exception(exception0)
   );

   multdiv_ctrl #(.ITER(1)) u1 (
      .clk(clk), .rst(rst), .ctrl_MULT(mult1), .ctrl_DIV(div1),
      .divisor_zero(dz), .mult_ovf(ovf),
      .dp_load(dp_load1), .dp_step(dp_step1), .dp_fix(dp_fix1), .dp_mode(dp_mode1),
      .iter_idx(iter_idx1), .busy(busy1), .result_rdy(result_rdy1), .exception(exception1)
   );

   always #5 clk = ~clk;

   // Reference model: per DUT, whether an operation is live, the cycle of
   // its LOAD, its mode, whether a zero divisor was seen, captured overflow.
   int cyc = 0;
   bit act[2];
   int ld[2];
   bit md[2], dzf[2], ovff[2];
   int itv[2] = '{32, 1};

   // Expected {load,step,fix,mode,idx[5:0],busy,rdy,exc} in the current cycle.
   function automatic logic [12:0] expv(int k);
      logic [12:0] e;
      int r;
      e = '0;
      if (act[k]) begin
         r    = cyc - ld[k];
         e[9] = md[k];
         e[2] = 1'b1;
         if (r == 0) e[12] = 1'b1;
         else if (dzf[k]) begin
            if (r == 1) begin e[1] = 1'b1; e[0] = 1'b1; end
         end
         else if (r <= itv[k]) begin e[11] = 1'b1; e[8:3] = 6'(r - 1); end
         else if (r == itv[k] + 1) e[10] = 1'b1;
         else if (r == itv[k] + 2) begin e[1] = 1'b1; e[0] = ovff[k]; end
      end
      return e;
   endfunction

   // Advance one clock: fold this cycle's inputs into the model, clock the
   // DUTs, then drop the one-cycle start pulses.
   task automatic tick();
      bit st[2];
      bit ml[2];
      int r;
      bit fin;
      ml[0] = mult0; st[0] = mult0 | div0;
      ml[1] = mult1; st[1] = mult1 | div1;
      for (int k = 0; k < 2; k++) begin
         r = cyc - ld[k];
         if (act[k]) begin
            if (r == 0 && md[k] && dz) dzf[k] = 1'b1;
            if (!dzf[k] && !md[k] && r == itv[k] + 1) ovff[k] = ovf;
         end
         fin = act[k] && (dzf[k] ? (r == 1) : (r == itv[k] + 2));
         if (rst) act[k] = 1'b0;
         else if (st[k]) begin
            act[k] = 1'b1; ld[k] = cyc + 1; md[k] = !ml[k];
            dzf[k] = 1'b0; ovff[k] = 1'b0;
         end
         else if (fin) act[k] = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      mult0 = 1'b0; div0 = 1'b0; mult1 = 1'b0; div1 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ntests++;
      if (obs0 !== 13'd0) begin nfail++; $display("FAIL reset0 got=%h exp=0", obs0); end
      ntests++;
      if (obs1 !== 13'd0) begin nfail++; $display("FAIL reset1 got=%h exp=0", obs1); end
   endtask

   task automatic test_mult();
      mult0 = 1'b1; ovf = 1'b0;
      tick();
      for (int i = 1; i <= 36; i++) begin
         ntests++;
         if (obs0 !== expv(0)) begin nfail++; $display("FAIL mult c%0d got=%h exp=%h", i, obs0, expv(0)); end
         if (i == 35) begin
            ntests++;
            if ({result_rdy0, exception0} !== 2'b10) begin nfail++; $display("FAIL mult_done got=%b exp=10", {result_rdy0, exception0}); end
         end
         if (i == 36) begin
            ntests++;
            if (busy0 !== 1'b0) begin nfail++; $display("FAIL mult_idle busy got=%b exp=0", busy0); end
         end
         ovf = (i == 34) ? 1'b0 : 1'($urandom);
         dz  = 1'($urandom);
         tick();
      end
   endtask

   task automatic test_divzero();
      div0 = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         ntests++;
         if (obs0 !== expv(0)) begin nfail++; $display("FAIL divzero c%0d got=%h exp=%h", i, obs0, expv(0)); end
         if (i == 2) begin
            ntests++;
            if ({result_rdy0, exception0, dp_mode0} !== 3'b111) begin nfail++; $display("FAIL divzero_done got=%b exp=111", {result_rdy0, exception0, dp_mode0}); end
         end
         dz  = (i == 1) ? 1'b1 : 1'($urandom);
         ovf = 1'($urandom);
         tick();
      end
   endtask

   task automatic test_mult_ovf();
      for (int run = 0; run < 2; run++) begin
         mult0 = 1'b1;
         tick();
         for (int i = 1; i <= 36; i++) begin
            ntests++;
            if (obs0 !== expv(0)) begin nfail++; $display("FAIL ovf r%0d c%0d got=%h exp=%h", run, i, obs0, expv(0)); end
            if (i == 35) begin
               ntests++;
               if (exception0 !== (run == 0)) begin nfail++; $display("FAIL ovf_exc r%0d got=%b exp=%b", run, exception0, run == 0); end
            end
            if (i >= 2 && i <= 33) ovf = 1'b1;
            else if (i == 34)      ovf = (run == 0);
            else                   ovf = 1'($urandom);
            dz = 1'($urandom);
            tick();
         end
      end
   endtask

   task automatic test_abort();
      int rdy_cnt;
      rdy_cnt = 0;
      mult0 = 1'b1;
      tick();
      for (int i = 1; i <= 47; i++) begin
         ntests++;
         if (obs0 !== expv(0)) begin nfail++; $display("FAIL abort c%0d got=%h exp=%h", i, obs0, expv(0)); end
         if (result_rdy0 === 1'b1) rdy_cnt++;
         if (i == 11) begin
            ntests++;
            if ({dp_load0, dp_mode0} !== 2'b11) begin nfail++; $display("FAIL abort_load got=%b exp=11", {dp_load0, dp_mode0}); end
         end
         // Restart LOAD at 11 puts DONE at 11 + ITER + 2.
         if (i == 45) begin
            ntests++;
            if (result_rdy0 !== 1'b1) begin nfail++; $display("FAIL abort_done got=%b exp=1", result_rdy0); end
         end
         if (i == 10) div0 = 1'b1;
         dz  = (i == 11) ? 1'b0 : 1'($urandom);
         ovf = 1'($urandom);
         tick();
      end
      ntests++;
      if (rdy_cnt != 1) begin nfail++; $display("FAIL abort_rdy_count got=%0d exp=1", rdy_cnt); end
   endtask

   task automatic test_simul();
      mult0 = 1'b1; div0 = 1'b1;
      tick();
      for (int i = 1; i <= 36; i++) begin
         ntests++;
         if (obs0 !== expv(0)) begin nfail++; $display("FAIL simul c%0d got=%h exp=%h", i, obs0, expv(0)); end
         if (i == 1) begin
            ntests++;
            if ({dp_load0, dp_mode0} !== 2'b10) begin nfail++; $display("FAIL simul_mode got=%b exp=10", {dp_load0, dp_mode0}); end
         end
         dz  = 1'($urandom);
         ovf = 1'($urandom);
         tick();
      end
   endtask

   task automatic test_reset_mid();
      mult0 = 1'b1;
      tick();
      for (int i = 1; i <= 58; i++) begin
         ntests++;
         if (obs0 !== expv(0)) begin nfail++; $display("FAIL rstmid c%0d got=%h exp=%h", i, obs0, expv(0)); end
         if (i == 21) begin
            ntests++;
            if (obs0 !== 13'd0) begin nfail++; $display("FAIL rstmid_zero got=%h exp=0", obs0); end
         end
         if (i == 57) begin
            ntests++;
            if ({result_rdy0, exception0} !== 2'b10) begin nfail++; $display("FAIL rstmid_done got=%b exp=10", {result_rdy0, exception0}); end
         end
         rst = (i == 20);
         if (i == 22) div0 = 1'b1;
         dz  = (i == 23) ? 1'b0 : 1'($urandom);
         ovf = 1'($urandom);
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_iter1();
      int steps;
      steps = 0;
      mult1 = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) begin
         ntests++;
         if (obs1 !== expv(1)) begin nfail++; $display("FAIL iter1 c%0d got=%h exp=%h", i, obs1, expv(1)); end
         if (dp_step1 === 1'b1) steps++;
         if (i == 4) begin
            ntests++;
            if (result_rdy1 !== 1'b1) begin nfail++; $display("FAIL iter1_done got=%b exp=1", result_rdy1); end
         end
         dz  = 1'($urandom);
         ovf = 1'($urandom);
         tick();
      end
      ntests++;
      if (steps != 1) begin nfail++; $display("FAIL iter1_steps got=%0d exp=1", steps); end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 3000; i++) begin
         ntests++;
         if (obs0 !== expv(0)) begin nfail++; $display("FAIL rand0 cyc%0d got=%h exp=%h", cyc, obs0, expv(0)); end
         ntests++;
         if (obs1 !== expv(1)) begin nfail++; $display("FAIL rand1 cyc%0d got=%h exp=%h", cyc, obs1, expv(1)); end
         ntests++;
         if ($countones({dp_load0, dp_step0, dp_fix0, result_rdy0}) > 1) begin
            nfail++; $display("FAIL rand_excl cyc%0d got=%b exp=onehot0", cyc, {dp_load0, dp_step0, dp_fix0, result_rdy0});
         end
         r = $urandom_range(0, 99);
         mult0 = (r < 1) || (r == 2);
         div0  = (r == 1) || (r == 2);
         r = $urandom_range(0, 99);
         mult1 = (r < 8) || (r >= 14 && r < 16);
         div1  = (r >= 8 && r < 16);
         rst = ($urandom_range(0, 599) == 0);
         dz  = 1'($urandom);
         ovf = 1'($urandom);
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_divzero();
      test_mult_ovf();
      test_abort();
      test_simul();
      test_reset_mid();
      test_iter1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
